// File: rtl/dff_pipe_elastic.sv
// Elastic delay line: DEPTH register stages with per-stage valid bits, valid/ready
// backpressure, bubble collapsing, synchronous flush and an occupancy count.
module dff_pipe_elastic #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [WIDTH-1:0] dat_q [DEPTH];
    logic [WIDTH-1:0] dat_d [DEPTH];

    logic [DEPTH-1:0] rdy;
    logic             rdy_chain;
    logic [DEPTH-1:0] up_vld;
    logic [WIDTH-1:0] up_dat [DEPTH];

    // Ready ripples from the output back to stage 0; an empty stage is always ready.
    always_comb begin
        rdy       = '0;
        rdy_chain = out_ready;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            rdy[DEPTH-1-k] = ~vld_q[DEPTH-1-k] | rdy_chain;
            rdy_chain      = rdy[DEPTH-1-k];
        end
    end

    assign in_ready = rdy[0] & ~flush;

    always_comb begin
        up_vld[0] = in_valid & ~flush;
        up_dat[0] = in_data;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            up_vld[i] = vld_q[i-1];
            up_dat[i] = dat_q[i-1];
        end
    end

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rdy[i]) begin
                vld_d[i] = up_vld[i];
                // Data only moves with a valid beat, so an emptied stage keeps its last value.
                if (up_vld[i]) begin
                    dat_d[i] = up_dat[i];
                end
            end
        end
        if (rst || flush) begin
            vld_d = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dat_d[i] = RESET_VAL;
            end
        end
    end

    always_ff @(posedge clk) begin
        vld_q <= vld_d;
        dat_q <= dat_d;
    end

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(vld_q[i]);
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];

endmodule

// File: tb/tb_dff_pipe_elastic.sv
// Bench for dff_pipe_elastic: queue-of-beats model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_dff_pipe_elastic;

    localparam int unsigned D  = 4;
    localparam logic [7:0]  RV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] occupancy;

    dff_pipe_elastic #(
        .WIDTH     (8),
        .DEPTH     (D),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         p;
    } beat_t;

    beat_t      mq[$];
    bit         mv[D];
    logic [7:0] m_last;
    logic [7:0] dut_out[$];
    int         n_cmp = 0;
    int         n_err = 0;
    bit         chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    // Oldest beat first: it advances if the slot ahead is free or its occupant leaves.
    function automatic void compute_moves();
        for (int i = 0; i < mq.size(); i++) begin
            if (i == 0) mv[0] = (mq[0].p == int'(D) - 1) ? out_ready : 1'b1;
            else if (mq[i-1].p == mq[i].p + 1) mv[i] = mv[i-1];
            else mv[i] = 1'b1;
        end
    endfunction

    function automatic bit model_in_ready();
        compute_moves();
        return !flush && (mq.size() == 0 || mq[mq.size()-1].p > 0 || mv[mq.size()-1]);
    endfunction

    function automatic void model_step();
        beat_t nq[$];
        beat_t b;
        bit    acc;
        if (rst || flush) begin
            mq.delete();
            m_last = RV;
            return;
        end
        acc = in_valid && model_in_ready();
        for (int i = 0; i < mq.size(); i++) begin
            b = mq[i];
            if (mv[i]) begin
                if (b.p == int'(D) - 1) continue;
                b.p++;
                if (b.p == int'(D) - 1) m_last = b.d;
            end
            nq.push_back(b);
        end
        if (acc) begin
            b.d = in_data;
            b.p = 0;
            if (D == 1) m_last = in_data;
            nq.push_back(b);
        end
        mq = nq;
    endfunction

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        #3;
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(mq.size() > 0 && mq[0].p == int'(D) - 1));
            chk("out_data", 32'(out_data), 32'(m_last));
            chk("occupancy", 32'(occupancy), 32'(mq.size()));
            chk("in_ready", 32'(in_ready), 32'(model_in_ready()));
            if (out_valid && out_ready) dut_out.push_back(out_data);
        end
    end

    task automatic tick(input bit v, input logic [7:0] d, input bit o, input bit f);
        @(negedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = o;
        flush     = f;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    logic [7:0] t2_dat [3] = '{8'h11, 8'h22, 8'h33};
    int         t2_occ [7] = '{1, 2, 3, 3, 2, 1, 0};
    int         j;

    initial begin
        // 1: reset
        @(negedge clk);
        @(negedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'hA5);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // 2: latency and throughput
        dut_out.delete();
        for (int k = 0; k < 10; k++) begin
            tick(k < 3, (k < 3) ? t2_dat[k] : 8'h00, 1'b1, 1'b0);
            if (k >= 1 && k <= 7) chk("t2_occ", 32'(occupancy), 32'(t2_occ[k-1]));
            if (k >= 4 && k <= 6) begin
                chk("t2_valid", 32'(out_valid), 32'd1);
                chk("t2_data", 32'(out_data), 32'(t2_dat[k-4]));
            end
        end
        chk("t2_count", 32'(dut_out.size()), 32'd3);

        // 3: fill with output stalled, then drain
        dut_out.delete();
        j = 0;
        for (int c = 0; c < 6; c++) begin
            tick(1'b1, 8'(8'h40 + j), 1'b0, 1'b0);
            if (c == 4) begin
                chk("t3_in_ready", 32'(in_ready), 32'd0);
                chk("t3_occ", 32'(occupancy), 32'd4);
                chk("t3_head", 32'(out_data), 32'h40);
            end
            if (in_ready) j++;
        end
        chk("t3_accepted", 32'(j), 32'd4);
        for (int c = 0; c < 14; c++) begin
            tick(j < 6, 8'(8'h40 + j), 1'b1, 1'b0);
            if (in_valid && in_ready) j++;
        end
        chk("t3_count", 32'(dut_out.size()), 32'd6);
        for (int i = 0; i < 6 && i < dut_out.size(); i++)
            chk("t3_order", 32'(dut_out[i]), 32'(8'h40 + i));

        // 4: full chain with simultaneous push and pop
        dut_out.delete();
        for (int c = 0; c < 4; c++) tick(1'b1, 8'(8'h60 + c), 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            tick(1'b1, 8'(8'h70 + c), 1'b1, 1'b0);
            chk("t4_in_ready", 32'(in_ready), 32'd1);
            chk("t4_occ", 32'(occupancy), 32'd4);
        end
        for (int c = 0; c < 6; c++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_count", 32'(dut_out.size()), 32'd10);
        for (int i = 0; i < 10 && i < dut_out.size(); i++)
            chk("t4_order", 32'(dut_out[i]), (i < 4) ? 32'(8'h60 + i) : 32'(8'h70 + i - 4));

        // 5: bubble collapse behind a stalled head
        dut_out.delete();
        tick(1'b1, 8'hAA, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b1, 8'hBB, 1'b1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0);
            chk("t5_stall_valid", 32'(out_valid), 32'd1);
            chk("t5_stall_data", 32'(out_data), 32'hAA);
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5_occ", 32'(occupancy), 32'd2);
        chk("t5_a", 32'(out_data), 32'hAA);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5_b_valid", 32'(out_valid), 32'd1);
        chk("t5_b", 32'(out_data), 32'hBB);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5_empty", 32'(out_valid), 32'd0);

        // 6: flush with a same-cycle input beat
        dut_out.delete();
        tick(1'b1, 8'hC1, 1'b0, 1'b0);
        tick(1'b1, 8'hC2, 1'b0, 1'b0);
        tick(1'b1, 8'hC3, 1'b0, 1'b0);
        tick(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("t6_pre_occ", 32'(occupancy), 32'd3);
        chk("t6_flush_in_ready", 32'(in_ready), 32'd0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t6_occ", 32'(occupancy), 32'd0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_data", 32'(out_data), 32'hA5);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        for (int c = 0; c < 6; c++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t6_nothing_out", 32'(dut_out.size()), 32'd0);

        // 7: reset mid-stream
        dut_out.delete();
        tick(1'b1, 8'h51, 1'b1, 1'b0);
        tick(1'b1, 8'h52, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("t7_occ", 32'(occupancy), 32'd0);
        chk("t7_data", 32'(out_data), 32'hA5);
        for (int c = 0; c < 6; c++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t7_nothing_out", 32'(dut_out.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
